// File: rtl/quad_multi.sv
// quad_multi: multi-channel quadrature decoder for paddle/spinner inputs.
// Each channel synchronises and debounces its A/B pins, decodes Gray-code
// transitions into an up/down position counter and emits per-step pulses.
//
// Parameters:
//   CHANNELS  number of independent channels (1..8)
//   WIDTH     position counter width (2..16)
//   FILTER    debounce depth in clocks (0 = none, max 15)
//   WRAP      0 = saturate at 0 / 2^WIDTH-1, 1 = modulo wrap
//
// Ports:
//   clk      system clock
//   resetn   asynchronous active-low reset
//   quad_a   phase A pins (asynchronous)
//   quad_b   phase B pins (asynchronous)
//   clear    synchronous clear of positions and error flags
//   pos      positions, channel n at [n*WIDTH +: WIDTH]
//   step     one-cycle pulse per accepted valid transition
//   dir      direction of the last valid transition (1 = up)
//   err      sticky illegal-transition flags
//
// Optional feature: define QUAD_ERR_EN to enable err reporting; otherwise
// err is tied low and illegal transitions are silently ignored.
module quad_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 7,
  parameter int FILTER   = 3,
  parameter int WRAP     = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       quad_a,
  input  logic [CHANNELS-1:0]       quad_b,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] pos,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       err
);
  localparam logic [3:0]       FILT = 4'(FILTER);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TOP  = {WIDTH{1'b1}};

  // ready[1] marks the first clock on which sync2 holds real pin values.
  logic [1:0] ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ready <= 2'b00;
    else         ready <= {ready[0], 1'b1};
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]       sync1, sync2, accepted, prev;
    logic [3:0]       cnt [2];
    logic             primed;
    logic [1:0]       idx_old, idx_new, delta;
    logic             fwd, rev;
    logic [WIDTH-1:0] pos_q;
    logic             step_q, dir_q;

    // Pin pair is packed as {A, B}.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync1    <= 2'b00;
        sync2    <= 2'b00;
        accepted <= 2'b00;
        prev     <= 2'b00;
        primed   <= 1'b0;
        cnt[0]   <= 4'd0;
        cnt[1]   <= 4'd0;
      end else begin
        sync1 <= {quad_a[c], quad_b[c]};
        sync2 <= sync1;
        if (!primed) begin
          // Load the pin state seen at reset release without counting it.
          if (ready[1]) begin
            accepted <= sync2;
            prev     <= sync2;
            primed   <= 1'b1;
          end
        end else begin
          prev <= accepted;
          for (int k = 0; k < 2; k++) begin
            if (sync2[k] == accepted[k]) begin
              cnt[k] <= 4'd0;
            end else if (cnt[k] == FILT) begin
              accepted[k] <= sync2[k];
              cnt[k]      <= 4'd0;
            end else begin
              cnt[k] <= cnt[k] + 4'd1;
            end
          end
        end
      end
    end

    // Position along the forward cycle 00,01,11,10 is {A, A^B}; the modulo-4
    // difference is 1 forward, 3 reverse, 2 illegal.
    assign idx_old = {prev[1], prev[1] ^ prev[0]};
    assign idx_new = {accepted[1], accepted[1] ^ accepted[0]};
    assign delta   = idx_new - idx_old;
    assign fwd     = (delta == 2'd1);
    assign rev     = (delta == 2'd3);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        pos_q  <= '0;
        step_q <= 1'b0;
        dir_q  <= 1'b0;
      end else begin
        step_q <= fwd | rev;
        if (fwd | rev) dir_q <= fwd;
        if (clear) begin
          pos_q <= '0;
        end else if (fwd) begin
          if (WRAP != 0 || pos_q != TOP) pos_q <= pos_q + ONE;
        end else if (rev) begin
          if (WRAP != 0 || pos_q != '0) pos_q <= pos_q - ONE;
        end
      end
    end

    assign pos[c*WIDTH +: WIDTH] = pos_q;
    assign step[c]               = step_q;
    assign dir[c]                = dir_q;

`ifdef QUAD_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)             err_q <= 1'b0;
      else if (clear)          err_q <= 1'b0;
      else if (delta == 2'd2)  err_q <= 1'b1;
    end

    assign err[c] = err_q;
`else
    assign err[c] = 1'b0;
`endif
  end

endmodule
